// File: rtl/gpio_conv_ctrl.sv
// Host-GPIO command decoder for a 3x3 convolution engine: kernel/length setup, image line
// loading, start/done handshake and result readback. Define GPIO_SYNC_EN to add a 2-flop input synchronizer.
module gpio_conv_ctrl #(
  parameter int GPIO_D = 32,
  parameter int DATA_W = 24,
  parameter int N_MEM  = 4,
  parameter int N_OUT  = 2,
  parameter int ADDR_W = 10,
  parameter int OUT_W  = 13
) (
  input  logic                                     CLK100MHZ,
  input  logic                                     i_rst,
  input  logic [GPIO_D-1:0]                        i_gpio_o,
  output logic [GPIO_D-1:0]                        o_gpio_i,
  output logic [3*DATA_W-1:0]                      o_kernel,
  output logic [ADDR_W-1:0]                        o_img_len,
  output logic [N_MEM-1:0]                         o_mem_we,
  output logic [ADDR_W-1:0]                        o_mem_addr,
  output logic [DATA_W-1:0]                        o_mem_wdata,
  output logic                                     o_start,
  input  logic                                     i_done,
  output logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] o_rd_sel,
  output logic [ADDR_W-1:0]                        o_rd_addr,
  input  logic [OUT_W-1:0]                         i_rd_data,
  output logic                                     o_led
);

  localparam int SEL_W  = $clog2(N_MEM + 1);
  localparam int RSEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [2:0] C_KERN = 3'b000;
  localparam logic [2:0] C_LEN  = 3'b001;
  localparam logic [2:0] C_WR   = 3'b010;
  localparam logic [2:0] C_READ = 3'b011;
  localparam logic [2:0] C_LAST = 3'b100;

  typedef enum logic [1:0] {IDLE = 2'b00, LOAD = 2'b01, RUN = 2'b10, READ = 2'b11} state_t;

  logic [GPIO_D-1:0] gpio_s;

`ifdef GPIO_SYNC_EN
  logic [GPIO_D-1:0] sync1_q, sync2_q;

  always_ff @(posedge CLK100MHZ) begin
    if (i_rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_gpio_o;
      sync2_q <= sync1_q;
    end
  end

  assign gpio_s = sync2_q;
`else
  assign gpio_s = i_gpio_o;
`endif

  // ctrl and data share the valid register so each edge sees the fields that arrived with it
  logic              vld_q, vld_prev_q;
  logic [2:0]        ctrl_q;
  logic [DATA_W-1:0] data_q;
  logic              unused_gpio_bits;

  assign unused_gpio_bits = ^{gpio_s[0], gpio_s[GPIO_D-5:DATA_W+1]};

  always_ff @(posedge CLK100MHZ) begin
    if (i_rst) begin
      vld_q      <= 1'b0;
      vld_prev_q <= 1'b0;
      ctrl_q     <= '0;
      data_q     <= '0;
    end else begin
      vld_q      <= gpio_s[GPIO_D-4];
      vld_prev_q <= vld_q;
      ctrl_q     <= gpio_s[GPIO_D-1 -: 3];
      data_q     <= gpio_s[DATA_W:1];
    end
  end

  state_t            state_q;
  logic [DATA_W-1:0] kern_q [3];
  logic [1:0]        krow_q;
  logic [ADDR_W-1:0] img_len_q, addr_q, mem_addr_q, rd_addr_q;
  logic [SEL_W-1:0]  sel_q;
  logic [RSEL_W-1:0] rd_sel_q;
  logic [N_MEM-1:0]  we_q;
  logic [DATA_W-1:0] wdata_q;
  logic [OUT_W-1:0]  result_q;
  logic              start_pend_q, start_q, done_q, ovf_q;

  logic edge_w, wr_req, mem_full, addr_wrap;

  assign edge_w    = vld_q & ~vld_prev_q;
  assign wr_req    = edge_w && (((state_q == IDLE) && (ctrl_q == C_WR)) ||
                                ((state_q == LOAD) && ((ctrl_q == C_WR) || (ctrl_q == C_LAST))));
  assign mem_full  = (sel_q == SEL_W'(N_MEM));
  assign addr_wrap = (addr_q == img_len_q);

  always_ff @(posedge CLK100MHZ) begin
    if (i_rst) begin
      state_q      <= IDLE;
      for (int r = 0; r < 3; r++) kern_q[r] <= '0;
      krow_q       <= '0;
      img_len_q    <= '0;
      addr_q       <= '0;
      sel_q        <= '0;
      mem_addr_q   <= '0;
      wdata_q      <= '0;
      we_q         <= '0;
      rd_addr_q    <= '0;
      rd_sel_q     <= '0;
      result_q     <= '0;
      start_pend_q <= 1'b0;
      start_q      <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      we_q         <= '0;
      start_q      <= start_pend_q;
      start_pend_q <= 1'b0;
      result_q     <= i_rd_data;

      // The final word of a load sits at img_len before the counters wrap
      if (wr_req) begin
        if (mem_full) begin
          ovf_q <= 1'b1;
        end else begin
          we_q       <= N_MEM'(1) << sel_q;
          mem_addr_q <= addr_q;
          wdata_q    <= data_q;
          if (addr_wrap) begin
            addr_q <= '0;
            sel_q  <= sel_q + SEL_W'(1);
          end else begin
            addr_q <= addr_q + ADDR_W'(1);
          end
        end
      end

      case (state_q)
        IDLE: begin
          if (ctrl_q == C_LEN) img_len_q <= data_q[ADDR_W-1:0];
          if (edge_w) begin
            case (ctrl_q)
              C_KERN: begin
                kern_q[krow_q] <= data_q;
                krow_q         <= (krow_q == 2'd2) ? 2'd0 : krow_q + 2'd1;
              end
              C_WR:   state_q <= LOAD;
              C_READ: begin
                if (done_q) begin
                  state_q   <= READ;
                  rd_sel_q  <= '0;
                  rd_addr_q <= '0;
                end
              end
              default: ;
            endcase
          end
        end
        LOAD: begin
          if (edge_w && (ctrl_q == C_LAST)) begin
            addr_q       <= '0;
            sel_q        <= '0;
            start_pend_q <= 1'b1;
            state_q      <= RUN;
          end
        end
        RUN: begin
          // A done level still high from the previous job must not end this one
          if (i_done && !start_pend_q && !start_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        READ: begin
          if (edge_w) begin
            if (rd_addr_q == img_len_q - ADDR_W'(2)) begin
              rd_addr_q <= '0;
              if (rd_sel_q == RSEL_W'(N_OUT - 1)) begin
                rd_sel_q <= '0;
                done_q   <= 1'b0;
                state_q  <= IDLE;
              end else begin
                rd_sel_q <= rd_sel_q + RSEL_W'(1);
              end
            end else begin
              rd_addr_q <= rd_addr_q + ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_gpio_i                 = '0;
    o_gpio_i[GPIO_D-1]       = done_q;
    o_gpio_i[GPIO_D-2]       = ovf_q;
    o_gpio_i[GPIO_D-3 -: 2]  = state_q;
    o_gpio_i[OUT_W-1:0]      = result_q;
  end

  assign o_kernel    = {kern_q[2], kern_q[1], kern_q[0]};
  assign o_img_len   = img_len_q;
  assign o_mem_we    = we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_start     = start_q;
  assign o_rd_sel    = rd_sel_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_led       = done_q;

endmodule

// File: tb/tb_gpio_conv_ctrl.sv
// Directed-sequence bench for gpio_conv_ctrl with random payloads checked against a
// count-based reference model (write index -> memory/address, read index -> sel/address).
module tb_gpio_conv_ctrl;

  localparam int GPIO_D = 32;
  localparam int DATA_W = 24;
  localparam int N_MEM  = 4;
  localparam int N_OUT  = 2;
  localparam int ADDR_W = 10;
  localparam int OUT_W  = 13;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [GPIO_D-1:0]   gpio = '0;
  logic                done_in = 1'b0;
  logic [OUT_W-1:0]    rd_data = '0;
  logic [GPIO_D-1:0]   gpio_rb;
  logic [3*DATA_W-1:0] kernel;
  logic [ADDR_W-1:0]   img_len, mem_addr, rd_addr;
  logic [N_MEM-1:0]    mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic                start, led;
  logic [0:0]          rd_sel;

  gpio_conv_ctrl #(
    .GPIO_D(GPIO_D), .DATA_W(DATA_W), .N_MEM(N_MEM),
    .N_OUT(N_OUT), .ADDR_W(ADDR_W), .OUT_W(OUT_W)
  ) dut (
    .CLK100MHZ  (clk),
    .i_rst      (rst),
    .i_gpio_o   (gpio),
    .o_gpio_i   (gpio_rb),
    .o_kernel   (kernel),
    .o_img_len  (img_len),
    .o_mem_we   (mem_we),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_start    (start),
    .i_done     (done_in),
    .o_rd_sel   (rd_sel),
    .o_rd_addr  (rd_addr),
    .i_rd_data  (rd_data),
    .o_led      (led)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Write-port and start-pulse monitor
  logic [N_MEM-1:0]  mon_we[$];
  logic [ADDR_W-1:0] mon_addr[$];
  logic [DATA_W-1:0] mon_data[$];
  int n_start = 0, start_at = 0, last_wr = 0;

  always @(negedge clk) begin
    if (mem_we != '0) begin
      mon_we.push_back(mem_we);
      mon_addr.push_back(mem_addr);
      mon_data.push_back(mem_wdata);
      last_wr = cyc;
    end
    if (start) begin
      n_start++;
      start_at = cyc;
    end
  end

  // Result memory: data appears one cycle after the address
  logic [OUT_W-1:0] tab [N_OUT][16];
  always @(posedge clk) rd_data <= tab[rd_sel][rd_addr[3:0]];

  logic [DATA_W-1:0] krow [3];
  int                kp;
  logic [DATA_W-1:0] sent_d[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("comparison %s", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [2:0] c, input logic [DATA_W-1:0] d);
    logic [GPIO_D-1:0] w;
    w = '0;
    w[GPIO_D-1 -: 3]        = c;
    w[GPIO_D-4]             = 1'b1;
    w[DATA_W:1]             = d;
    w[0]                    = 1'($urandom);
    w[GPIO_D-5:DATA_W+1]    = (GPIO_D-DATA_W-5)'($urandom);
    gpio = w;
    tick(4);
    gpio = '0;
    gpio[0] = 1'($urandom);
    tick(4);
  endtask

  task automatic set_len(input logic [ADDR_W-1:0] l);
    logic [GPIO_D-1:0] w;
    w = '0;
    w[GPIO_D-1 -: 3] = 3'b001;
    w[ADDR_W:1]      = l;
    gpio = w;
    tick(4);
    gpio = '0;
    tick(2);
  endtask

  task automatic do_reset(input string tag);
    gpio = '0;
    rst  = 1'b1;
    tick(2);
    check({tag, "_gpio_i"}, gpio_rb, '0);
    check({tag, "_kernel"}, kernel, '0);
    check({tag, "_img_len"}, img_len, '0);
    check({tag, "_we_addr_data"}, {mem_we, mem_addr, mem_wdata}, '0);
    check({tag, "_start_led"}, {start, led}, '0);
    check({tag, "_rd"}, {rd_sel, rd_addr}, '0);
    rst = 1'b0;
    for (int r = 0; r < 3; r++) krow[r] = '0;
    kp = 0;
    tick(1);
  endtask

  // Expected write n: memory n/(L+1), address n%(L+1); beyond N_MEM memories nothing is written
  task automatic check_writes(input string tag, input int l, input int total);
    int nexp;
    nexp = (total < N_MEM * (l + 1)) ? total : N_MEM * (l + 1);
    check({tag, "_count"}, mon_we.size(), nexp);
    for (int n = 0; n < nexp && n < mon_we.size(); n++) begin
      check($sformatf("%s_we%0d", tag, n), mon_we[n], N_MEM'(1) << (n / (l + 1)));
      check($sformatf("%s_addr%0d", tag, n), mon_addr[n], n % (l + 1));
      check($sformatf("%s_data%0d", tag, n), mon_data[n], sent_d[n]);
    end
  endtask

  task automatic clear_mon();
    mon_we.delete();
    mon_addr.delete();
    mon_data.delete();
    sent_d.delete();
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] kvals [4];
    logic [ADDR_W-1:0] snap_addr;
    logic [DATA_W-1:0] snap_data;
    int                st0;

    for (int s = 0; s < N_OUT; s++)
      for (int a = 0; a < 16; a++) tab[s][a] = OUT_W'($urandom);

    do_reset("rst0");

    // Kernel rows: three fixed rows, a fourth overwriting row0, then random ones
    kvals[0] = 24'h002000; kvals[1] = 24'h208020; kvals[2] = 24'h002000; kvals[3] = 24'h111111;
    for (int i = 0; i < 4; i++) begin
      send(3'b000, kvals[i]);
      krow[kp] = kvals[i];
      kp = (kp + 1) % 3;
      if (i == 2) check("kern_3rows", kernel, {24'h002000, 24'h208020, 24'h002000});
      if (i == 3) check("kern_row0_over", kernel, {24'h002000, 24'h208020, 24'h111111});
    end
    for (int i = 0; i < 3; i++) begin
      d = DATA_W'($urandom);
      send(3'b000, d);
      krow[kp] = d;
      kp = (kp + 1) % 3;
      check($sformatf("kern_rand%0d", i), kernel, {krow[2], krow[1], krow[0]});
    end

    set_len(10'd15);
    check("img_len15", img_len, 15);

    // 64-word image load, last word on ctrl=100
    clear_mon();
    for (int n = 0; n < 64; n++) begin
      d = DATA_W'($urandom);
      sent_d.push_back(d);
      send((n == 63) ? 3'b100 : 3'b010, d);
      if (n == 62) check("state_load", gpio_rb[GPIO_D-3 -: 2], 2'b01);
    end
    check_writes("load64", 15, 64);
    check("start_count", n_start, 1);
    check("start_after_last_wr", start_at - last_wr, 1);
    check("state_run", gpio_rb[GPIO_D-3 -: 2], 2'b10);
    check("ovf_clear", gpio_rb[GPIO_D-2], 1'b0);

    // RUN ignores edges; i_done finishes
    snap_addr = mem_addr;
    snap_data = mem_wdata;
    send(3'b010, DATA_W'($urandom));
    send(3'b011, DATA_W'($urandom));
    send(3'b100, DATA_W'($urandom));
    check("run_no_wr", mon_we.size(), 64);
    check("run_wr_outs", {mem_addr, mem_wdata}, {snap_addr, snap_data});
    check("run_rd_outs", {rd_sel, rd_addr}, '0);
    check("run_state_hold", gpio_rb[GPIO_D-3 -: 2], 2'b10);
    check("run_led_low", led, 1'b0);
    done_in = 1'b1;
    tick(3);
    check("done_led", led, 1'b1);
    check("done_flag", gpio_rb[GPIO_D-1], 1'b1);
    check("done_idle", gpio_rb[GPIO_D-3 -: 2], 2'b00);
    done_in = 1'b0;
    tick(2);
    check("start_once", n_start, 1);

    // Readback: 14 words per output memory with img_len=15
    send(3'b011, DATA_W'($urandom));
    for (int j = 0; j < 28; j++) begin
      if (j > 0) send(3'($urandom), DATA_W'($urandom));
      check($sformatf("rd%0d_sel", j), rd_sel, j / 14);
      check($sformatf("rd%0d_addr", j), rd_addr, j % 14);
      check($sformatf("rd%0d_res", j), gpio_rb[OUT_W-1:0], tab[j / 14][j % 14]);
      check($sformatf("rd%0d_state", j), gpio_rb[GPIO_D-3 -: 2], 2'b11);
    end
    send(3'($urandom), DATA_W'($urandom));
    check("rd_end_led", led, 1'b0);
    check("rd_end_idle", gpio_rb[GPIO_D-3 -: 2], 2'b00);

    // 65th write without ctrl=100 is dropped and flags overflow
    do_reset("rst1");
    clear_mon();
    set_len(10'd15);
    for (int n = 0; n < 65; n++) begin
      d = DATA_W'($urandom);
      sent_d.push_back(d);
      send(3'b010, d);
      if (n == 63) check("ovf_before", gpio_rb[GPIO_D-2], 1'b0);
    end
    check("ovf_set", gpio_rb[GPIO_D-2], 1'b1);
    check_writes("ovf65", 15, 65);
    send(3'b010, DATA_W'($urandom));
    check("ovf_sticky", gpio_rb[GPIO_D-2], 1'b1);

    // img_len=0: one word per memory
    do_reset("rst2");
    clear_mon();
    for (int n = 0; n < 5; n++) begin
      d = DATA_W'($urandom);
      sent_d.push_back(d);
      send(3'b010, d);
    end
    check_writes("len0", 0, 5);
    check("len0_ovf", gpio_rb[GPIO_D-2], 1'b1);

    // Reset mid-load discards progress; a following ctrl=100 is ignored
    do_reset("rst3");
    clear_mon();
    set_len(10'd15);
    for (int n = 0; n < 5; n++) begin
      d = DATA_W'($urandom);
      sent_d.push_back(d);
      send(3'b010, d);
    end
    check_writes("pre_rst", 15, 5);
    do_reset("rst4");
    st0 = n_start;
    send(3'b100, DATA_W'($urandom));
    tick(4);
    check("post_rst_no_start", n_start, st0);
    check("post_rst_no_wr", mon_we.size(), 5);
    check("post_rst_idle", gpio_rb[GPIO_D-3 -: 2], 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gpio_conv_ctrl.md
GPIO_CONV_CTRL -- requirements
Module: gpio_conv_ctrl

Interface
REQ-001 SHALL have parameter GPIO_D, default 32, meaning GPIO word width.
REQ-002 SHALL have parameter DATA_W, default 24, meaning host data field width; must satisfy DATA_W <= GPIO_D-8.
REQ-003 SHALL have parameter N_MEM, default 4, meaning number of input line memories loaded.
REQ-004 SHALL have parameter N_OUT, default 2, meaning number of output memories read back.
REQ-005 SHALL have parameter ADDR_W, default 10, meaning memory address width.
REQ-006 SHALL have parameter OUT_W, default 13, meaning result word width.
REQ-007 SHALL have port CLK100MHZ, input, 1, the single clock; reset is synchronous and active-high.
REQ-008 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-009 SHALL have port i_gpio_o, input, GPIO_D, host word: ctrl [GPIO_D-1:GPIO_D-3], valid [GPIO_D-4], data [DATA_W:1]; bit 0 is ignored.
REQ-010 SHALL have port o_gpio_i, output, GPIO_D, status/readback word: done [GPIO_D-1], overflow [GPIO_D-2], state [GPIO_D-3:GPIO_D-4], result [OUT_W-1:0], other bits 0.
REQ-011 SHALL have port o_kernel, output, 3*DATA_W, kernel rows; row0 in the LSBs.
REQ-012 SHALL have port o_img_len, output, ADDR_W, last valid address per line.
REQ-013 SHALL have ports o_mem_we (N_MEM, one-hot), o_mem_addr (ADDR_W) and o_mem_wdata (DATA_W), all outputs, forming the image write port.
REQ-014 SHALL have port o_start, output, 1, one-cycle convolution start pulse.
REQ-015 SHALL have port i_done, input, 1, level signal indicating convolution complete.
REQ-016 SHALL have ports o_rd_sel (clog2(N_OUT)) and o_rd_addr (ADDR_W), both outputs, forming the result read address.
REQ-017 SHALL have port i_rd_data, input, OUT_W, result data, valid 1 cycle after address.
REQ-018 SHALL have port o_led, output, 1, equal to the done flag.

Function
REQ-019 SHALL detect a command only on the rising edge of valid; ctrl and data are sampled through the same pipeline as valid, so exactly one command is issued per valid pulse.
REQ-020 SHALL implement states IDLE(00), LOAD(01), RUN(10), READ(11); IDLE accepts ctrl codes 000, 001, 010 and 011 (the last only when done=1).
REQ-021 ctrl=000 edge SHALL write data into kernel row k, then advance k = (k+1) mod 3; the fourth write overwrites row0.
REQ-022 While ctrl=001, the block SHALL load o_img_len from data[ADDR_W-1:0] every cycle, with no valid edge required; this is honoured in IDLE only.
REQ-023 ctrl=010 edge SHALL assert o_mem_we[sel] for 1 cycle with the current addr and data, then advance addr; if addr==img_len, addr SHALL become 0 and sel SHALL become sel+1; the state SHALL enter LOAD.
REQ-024 When sel==N_MEM (all memories full), further writes SHALL be suppressed, overflow SHALL be set, and overflow SHALL stay set until reset.
REQ-025 ctrl=100 edge in LOAD SHALL perform the same write as REQ-023, then pulse o_start exactly 1 cycle later and go to RUN; addr and sel SHALL clear.
REQ-026 In RUN, all valid edges SHALL be ignored; i_done=1 SHALL set done and return the state to IDLE.
REQ-027 i_done SHALL be ignored outside RUN.
REQ-028 ctrl=011 edge with done=1 SHALL enter READ with rd_sel=0 and rd_addr=0; each later valid edge SHALL advance rd_addr, wrapping after img_len-2 to 0 with rd_sel+1.
REQ-029 After the last word of memory N_OUT-1, the block SHALL clear done and return to IDLE.
REQ-030 o_gpio_i result field SHALL be registered from i_rd_data, so it is stable 2 cycles after an address change.
REQ-031 A write edge coinciding with the addr wrap condition SHALL write at addr=img_len before wrapping.
REQ-032 img_len=0 SHALL be legal: 1 word per memory.

Reset
REQ-033 i_rst SHALL clear state to IDLE, kernel, img_len, addr, sel, rd counters, done, overflow and the edge pipeline; all outputs SHALL be 0 the cycle after reset.
REQ-034 A reset mid-LOAD or mid-READ SHALL discard progress, and no o_start SHALL follow.

Configuration
REQ-035 With macro GPIO_SYNC_EN defined, valid/ctrl/data SHALL pass through a 2-flop synchronizer before edge detection; action latency from valid rise is 3 cycles.
REQ-036 Without GPIO_SYNC_EN, a single register SHALL feed edge detection; action latency is 1 cycle.

Verification
REQ-037 Kernel pulses 0x002000, 0x208020, 0x002000 SHALL give o_kernel = {0x002000, 0x208020, 0x002000}; a 4th pulse 0x111111 SHALL replace row0 only.
REQ-038 img_len=15, N_MEM=4, 64 words with the last sent on ctrl=100 SHALL produce 16 writes per memory at addr 0..15 and a single o_start 1 cycle after the final write.
REQ-039 A 65th write without ctrl=100 SHALL be suppressed and set overflow; o_gpio_i[GPIO_D-2]=1.
REQ-040 i_done in RUN SHALL raise o_led; valid edges during RUN SHALL leave all write and read outputs unchanged.
REQ-041 READ with img_len=15 and N_OUT=2 SHALL produce addresses 0..13 on sel 0 then 0..13 on sel 1; after 28 edges o_led=0 and state is IDLE.
REQ-042 i_rst asserted after 5 image writes SHALL return all outputs to 0; a following ctrl=100 SHALL be ignored (IDLE) and no o_start SHALL occur.
